// File: rtl/dsp_acc_pkg.sv
// Shared types and helpers for the dot-product accumulator stage: default widths,
// state encoding, sign extension and signed-overflow detect.
package dsp_acc_pkg;
  localparam int PW_DEF   = 43;
  localparam int ACCW_DEF = 48;
  localparam int W_MAX    = 64;  // widest product/accumulator the helpers handle

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  // Sign-extend the low pw bits of p across the full W_MAX word.
  function automatic logic [W_MAX-1:0] sext_to_acc(input logic [W_MAX-1:0] p, input int pw);
    logic [W_MAX-1:0] r;
    r = p;
    for (int i = 0; i < W_MAX; i++)
      if (i >= pw) r[i] = p[pw-1];
    return r;
  endfunction

  // Two same-signed operands giving a differently-signed sum means the add wrapped.
  function automatic logic ovf_add(input logic a_s, input logic b_s, input logic s_s);
    return (a_s == b_s) && (s_s != a_s);
  endfunction
endpackage

// File: rtl/dsp_dot_acc_if.sv
// Product stream in, dot-product result out; both valid/ready.
interface dsp_dot_acc_if
  import dsp_acc_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int ACCW = ACCW_DEF
) ();
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_p;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_acc;
  logic            out_ovf;

  modport master (output in_valid, in_p, out_ready,
                  input  in_ready, out_valid, out_acc, out_ovf);
  modport slave  (input  in_valid, in_p, out_ready,
                  output in_ready, out_valid, out_acc, out_ovf);
endinterface

// File: rtl/dsp_acc_add.sv
// Registered accumulate/load adder with sticky signed-overflow; shaped for the
// DSP48E1 P-register feedback path. Next-state values are exported for capture.
module dsp_acc_add
  import dsp_acc_pkg::*;
#(
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [ACCW-1:0] b,
  output logic [ACCW-1:0] sum_nxt,
  output logic            ovf_nxt
);
  logic [ACCW-1:0] acc, sum_add;
  logic            ovf;

  always_comb begin
    sum_add = acc + b;
    sum_nxt = load ? b : sum_add;
    ovf_nxt = load ? 1'b0 : (ovf | ovf_add(acc[ACCW-1], b[ACCW-1], sum_add[ACCW-1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum_nxt;
      ovf <= ovf_nxt;
    end
  end
endmodule

// File: rtl/dsp_dot_acc.sv
// Sums LEN consecutive signed products into an ACCW result and holds it on a
// valid/ready output; a pending unaccepted result back-pressures the input.
module dsp_dot_acc
  import dsp_acc_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int LEN  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dsp_dot_acc_if.slave  bus
);
  localparam int            CW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic            in_rdy, beat, last, ovf_nxt;
  logic [ACCW-1:0] b, sum_nxt;

  assign in_rdy        = (state_q == ACC) || bus.out_ready;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == HOLD);
  assign beat          = bus.in_valid && in_rdy;
  assign last          = (cnt == LAST);
  assign b             = ACCW'(sext_to_acc(W_MAX'(bus.in_p), PW));

  dsp_acc_add #(.ACCW(ACCW)) u_add (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (beat),
    .load    (cnt == '0),
    .b       (b),
    .sum_nxt (sum_nxt),
    .ovf_nxt (ovf_nxt)
  );

  // A completing beat wins over a plain result accept: the new result reloads HOLD.
  always_comb begin
    state_d = state_q;
    if (beat && last)                           state_d = HOLD;
    else if (state_q == HOLD && bus.out_ready)  state_d = ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      bus.out_acc <= '0;
      bus.out_ovf <= 1'b0;
    end else if (beat) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        bus.out_acc <= sum_nxt;
        bus.out_ovf <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_dsp_dot_acc.sv
// Directed and randomized checks of dsp_dot_acc at LEN = 1, 2, 4, 16 and 4096.
module tb_dsp_dot_acc;
  import dsp_acc_pkg::*;
  localparam int PW = 43, ACCW = 48;
  localparam longint TWO48 = longint'(1) << 48;
  localparam longint MAXP  = (longint'(1) << 47) - 1;
  localparam longint MINP  = -(longint'(1) << 47);
  localparam longint PMAX  = (longint'(1) << 42) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  dsp_dot_acc_if #(.PW(PW), .ACCW(ACCW)) b4 ();
  dsp_dot_acc_if #(.PW(PW), .ACCW(ACCW)) b2 ();
  dsp_dot_acc_if #(.PW(PW), .ACCW(ACCW)) bk ();
  dsp_dot_acc_if #(.PW(PW), .ACCW(ACCW)) b1 ();
  dsp_dot_acc_if #(.PW(PW), .ACCW(ACCW)) b16 ();

  dsp_dot_acc #(.PW(PW), .ACCW(ACCW), .LEN(4))    u4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  dsp_dot_acc #(.PW(PW), .ACCW(ACCW), .LEN(2))    u2  (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  dsp_dot_acc #(.PW(PW), .ACCW(ACCW), .LEN(4096)) uk  (.clk(clk), .rst_n(rst_n), .bus(bk.slave));
  dsp_dot_acc #(.PW(PW), .ACCW(ACCW), .LEN(1))    u1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  dsp_dot_acc #(.PW(PW), .ACCW(ACCW), .LEN(16))   u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  // Reference: mathematical running sum, wrapped into the signed ACCW range with
  // the sticky flag raised whenever a wrap happens.
  function automatic void ref_group(input longint ps[$], output longint s, output bit o);
    s = 0; o = 1'b0;
    foreach (ps[i]) begin
      if (i == 0) s = ps[i];
      else begin
        s = s + ps[i];
        if (s > MAXP)      begin s = s - TWO48; o = 1'b1; end
        else if (s < MINP) begin s = s + TWO48; o = 1'b1; end
      end
    end
  endfunction

  task automatic beat4(input longint v);
    b4.in_valid = 1'b1; b4.in_p = PW'(v);
    #1;
    checks++;
    if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL beat4_in_ready: got %b exp 1", b4.in_ready); end
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 4;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", b4.out_valid); end
    if (b4.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b exp 1", b4.in_ready); end
    if (b4.out_acc !== '0)     begin errors++; $display("FAIL rst_out_acc: got %0h exp 0", b4.out_acc); end
    if (b16.out_ovf !== 1'b0)  begin errors++; $display("FAIL rst_out_ovf: got %b exp 0", b16.out_ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++;
    if (b16.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b exp 1", b16.in_ready); end
  endtask

  task automatic test_basic();
    longint vals[4] = '{1, 2, 3, -10};
    b4.out_ready = 1'b1;
    foreach (vals[i]) begin
      b4.in_valid = 1'b1; b4.in_p = PW'(vals[i]);
      #1;
      checks += 2;
      if (b4.in_ready !== 1'b1)  begin errors++; $display("FAIL basic_in_ready: got %b exp 1", b4.in_ready); end
      if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b exp 0 beat %0d", b4.out_valid, i); end
      @(posedge clk); #1;
    end
    b4.in_valid = 1'b0;
    checks += 3;
    if (b4.out_valid !== 1'b1)        begin errors++; $display("FAIL basic_valid: got %b exp 1", b4.out_valid); end
    if (b4.out_acc !== ACCW'(-4))     begin errors++; $display("FAIL basic_acc: got %0d exp -4", $signed(b4.out_acc)); end
    if (b4.out_ovf !== 1'b0)          begin errors++; $display("FAIL basic_ovf: got %b exp 0", b4.out_ovf); end
    @(posedge clk); #1;
    checks++;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b exp 0", b4.out_valid); end
  endtask

  task automatic test_stall();
    b4.out_ready = 1'b0;
    beat4(7); beat4(8); beat4(9); beat4(10);
    b4.in_valid = 1'b1; b4.in_p = PW'(100);
    repeat (5) begin
      #1;
      checks += 3;
      if (b4.in_ready !== 1'b0)   begin errors++; $display("FAIL stall_in_ready: got %b exp 0", b4.in_ready); end
      if (b4.out_valid !== 1'b1)  begin errors++; $display("FAIL stall_valid: got %b exp 1", b4.out_valid); end
      if (b4.out_acc !== ACCW'(34)) begin errors++; $display("FAIL stall_acc: got %0d exp 34", $signed(b4.out_acc)); end
      @(posedge clk); #1;
    end
    b4.out_ready = 1'b1;
    #1;
    checks++;
    if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", b4.in_ready); end
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    checks++;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL release_accept: got %b exp 0", b4.out_valid); end
    beat4(1); beat4(1); beat4(1);
    checks += 2;
    if (b4.out_valid !== 1'b1)     begin errors++; $display("FAIL stall_next_valid: got %b exp 1", b4.out_valid); end
    if (b4.out_acc !== ACCW'(103)) begin errors++; $display("FAIL stall_next_acc: got %0d exp 103", $signed(b4.out_acc)); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    longint q[$];
    longint s; bit o;
    b2.out_ready = 1'b1;
    repeat (2) begin
      b2.in_valid = 1'b1; b2.in_p = PW'(PMAX);
      @(posedge clk); #1;
    end
    b2.in_valid = 1'b0;
    checks += 3;
    if (b2.out_valid !== 1'b1)                 begin errors++; $display("FAIL len2_valid: got %b exp 1", b2.out_valid); end
    if (b2.out_acc !== ACCW'(2 * PMAX))        begin errors++; $display("FAIL len2_acc: got %0h exp %0h", b2.out_acc, 2 * PMAX); end
    if (b2.out_ovf !== 1'b0)                   begin errors++; $display("FAIL len2_ovf: got %b exp 0", b2.out_ovf); end
    bk.out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      bk.in_valid = 1'b1; bk.in_p = PW'(PMAX); q.push_back(PMAX);
      @(posedge clk); #1;
    end
    bk.in_valid = 1'b0;
    ref_group(q, s, o);
    checks += 3;
    if (bk.out_valid !== 1'b1)     begin errors++; $display("FAIL len4096_valid: got %b exp 1", bk.out_valid); end
    if (bk.out_acc !== ACCW'(s))   begin errors++; $display("FAIL len4096_acc: got %0d exp %0d", $signed(bk.out_acc), s); end
    if (bk.out_ovf !== o)          begin errors++; $display("FAIL len4096_ovf: got %b exp %b", bk.out_ovf, o); end
    @(posedge clk); #1;
  endtask

  task automatic test_len1();
    longint vals[3] = '{5, -7, 0};
    b1.out_ready = 1'b1;
    foreach (vals[i]) begin
      b1.in_valid = 1'b1; b1.in_p = PW'(vals[i]);
      @(posedge clk); #1;
      checks += 3;
      if (b1.out_valid !== 1'b1)        begin errors++; $display("FAIL len1_valid: got %b exp 1", b1.out_valid); end
      if (b1.out_acc !== ACCW'(vals[i])) begin errors++; $display("FAIL len1_acc: got %0d exp %0d", $signed(b1.out_acc), vals[i]); end
      if (b1.out_ovf !== 1'b0)          begin errors++; $display("FAIL len1_ovf: got %b exp 0", b1.out_ovf); end
    end
    b1.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL len1_drain: got %b exp 0", b1.out_valid); end
  endtask

  task automatic test_reset_mid();
    b4.out_ready = 1'b1;
    beat4(50); beat4(60);
    rst_n = 1'b0; #1;
    checks += 2;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", b4.out_valid); end
    if (b4.in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_in_ready: got %b exp 1", b4.in_ready); end
    @(negedge clk) rst_n = 1'b1;
    b4.out_ready = 1'b0;
    beat4(9); beat4(9); beat4(9); beat4(9);
    rst_n = 1'b0; #1;
    checks += 2;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid: got %b exp 0", b4.out_valid); end
    if (b4.out_acc !== '0)     begin errors++; $display("FAIL rsthold_acc: got %0h exp 0", b4.out_acc); end
    @(negedge clk) rst_n = 1'b1;
    b4.out_ready = 1'b1;
    beat4(1); beat4(1); beat4(1); beat4(1);
    checks += 2;
    if (b4.out_valid !== 1'b1)   begin errors++; $display("FAIL rstmid_result_valid: got %b exp 1", b4.out_valid); end
    if (b4.out_acc !== ACCW'(4)) begin errors++; $display("FAIL rstmid_result_acc: got %0d exp 4", $signed(b4.out_acc)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    longint grp[$], exp_acc[$];
    bit exp_ovf[$];
    logic signed [PW-1:0] sp;
    logic [63:0] r64;
    longint s; bit o, pend;
    int beats = 0, cyc = 0, results = 0;
    while (beats < 10000 && cyc < 60000) begin
      r64 = {$urandom, $urandom};
      b16.in_valid  = ($urandom_range(0, 9) < 7);
      b16.in_p      = r64[PW-1:0];
      b16.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      pend = (exp_acc.size() != 0);
      checks += 2;
      if (b16.out_valid !== pend) begin errors++; $display("FAIL rnd_valid: got %b exp %b cyc %0d", b16.out_valid, pend, cyc); end
      if (b16.in_ready !== (!pend || b16.out_ready)) begin errors++; $display("FAIL rnd_in_ready: got %b exp %b cyc %0d", b16.in_ready, !pend || b16.out_ready, cyc); end
      if (pend && b16.out_ready) begin
        checks += 2;
        if (b16.out_acc !== ACCW'(exp_acc[0])) begin errors++; $display("FAIL rnd_acc: got %0d exp %0d", $signed(b16.out_acc), exp_acc[0]); end
        if (b16.out_ovf !== exp_ovf[0])        begin errors++; $display("FAIL rnd_ovf: got %b exp %b", b16.out_ovf, exp_ovf[0]); end
        void'(exp_acc.pop_front()); void'(exp_ovf.pop_front());
        results++;
      end
      if (b16.in_valid && (!pend || b16.out_ready)) begin
        sp = b16.in_p;
        grp.push_back(longint'(sp));
        beats++;
        if (grp.size() == 16) begin
          ref_group(grp, s, o);
          exp_acc.push_back(s); exp_ovf.push_back(o);
          grp.delete();
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (beats < 10000) begin errors++; $display("FAIL rnd_timeout: got %0d beats exp 10000", beats); end
    b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    #1;
    if (exp_acc.size() != 0) begin
      checks += 2;
      if (b16.out_valid !== 1'b1)            begin errors++; $display("FAIL rnd_drain_valid: got %b exp 1", b16.out_valid); end
      if (b16.out_acc !== ACCW'(exp_acc[0])) begin errors++; $display("FAIL rnd_drain_acc: got %0d exp %0d", $signed(b16.out_acc), exp_acc[0]); end
      void'(exp_acc.pop_front()); void'(exp_ovf.pop_front());
      results++;
    end
    @(posedge clk); #1;
    checks += 2;
    if (b16.out_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_valid: got %b exp 0", b16.out_valid); end
    if (results != 625)         begin errors++; $display("FAIL rnd_result_count: got %0d exp 625", results); end
  endtask

  initial begin
    b4.in_valid = 0;  b4.in_p = '0;  b4.out_ready = 0;
    b2.in_valid = 0;  b2.in_p = '0;  b2.out_ready = 0;
    bk.in_valid = 0;  bk.in_p = '0;  bk.out_ready = 0;
    b1.in_valid = 0;  b1.in_p = '0;  b1.out_ready = 0;
    b16.in_valid = 0; b16.in_p = '0; b16.out_ready = 0;
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_wide();
    test_len1();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: got timeout exp completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
